bnn_sign_packer: RTL and testbench

Binarizing packer for the binary convolution datapath. It consumes a stream of per-channel popcount results from the XNOR dot-product stage and thresholds each one back to a single binary activation (1'b1 = +1, 1'b0 = −1). It packs BW_BUS consecutive activations into one word for the next binary layer. It sits after the popcount stage and before the next layer's data bus, with valid/ready handshakes on both sides.

---
 rtl/bnn_pkg.sv | 21 ++
 rtl/bnn_sign_threshold.sv | 27 ++
 rtl/bnn_sign_packer.sv | 109 ++++++++++
 tb/tb_bnn_sign_packer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared encodings, width helper and packed output word for the binary conv datapath.
// Pure declarations: no latency or flow-control behaviour of its own.
package bnn_pkg;

    localparam logic BIN_POS = 1'b1;
    localparam logic BIN_NEG = 1'b0;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int BNN_BW_BUS = 8;
    localparam int BNN_NB_W   = cnt_width(BNN_BW_BUS);

    typedef struct packed {
        logic [BNN_BW_BUS-1:0] data;
        logic [BNN_NB_W-1:0]   nbits;
        logic                  last;
    } pack_word_t;

endpackage

// File: rtl/bnn_sign_threshold.sv
// Popcount -> activation bit; combinational, no backpressure. Fixed majority compare by
// default, runtime unsigned compare against i_thresh when BNN_SIGN_PACKER_THRESH_EN is defined.
module bnn_sign_threshold
    import bnn_pkg::*;
#(
    parameter  int N_TERMS = 9,
    localparam int CW      = cnt_width(N_TERMS)
) (
    input  logic [CW-1:0] i_data,
`ifdef BNN_SIGN_PACKER_THRESH_EN
    input  logic [CW-1:0] i_thresh,
`endif
    output logic          o_bit
);

`ifdef BNN_SIGN_PACKER_THRESH_EN
    assign o_bit = (i_data >= i_thresh) ? BIN_POS : BIN_NEG;
`else
    // 2*popcount - N_TERMS >= 0, evaluated one bit wider so the doubling never overflows.
    localparam logic [CW:0] NT = (CW + 1)'(N_TERMS);

    logic [CW:0] dbl;
    assign dbl   = {i_data, 1'b0};
    assign o_bit = (dbl >= NT) ? BIN_POS : BIN_NEG;
`endif

endmodule

// File: rtl/bnn_sign_packer.sv
// Thresholds popcounts and packs BW_BUS activations per word; output 1 cycle after closing accept.
// Single-entry output register; i_ready = !o_valid || o_ready. Runtime threshold with BNN_SIGN_PACKER_THRESH_EN.
module bnn_sign_packer
    import bnn_pkg::*;
#(
    parameter  int   BW_BUS  = 8,
    parameter  int   N_TERMS = 9,
    parameter  logic PAD_BIT = 1'b0,
    localparam int   CW      = cnt_width(N_TERMS),
    localparam int   NB_W    = cnt_width(BW_BUS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [CW-1:0]     i_data,
    input  logic              i_last,
`ifdef BNN_SIGN_PACKER_THRESH_EN
    input  logic [CW-1:0]     i_thresh,
`endif
    output logic              o_valid,
    input  logic              o_ready,
    output logic [BW_BUS-1:0] o_data,
    output logic [NB_W-1:0]   o_nbits,
    output logic              o_last
);

    // The output word type is shared with the next layer, so its width is fixed by the package.
    if (BW_BUS != BNN_BW_BUS || BW_BUS < 2) begin : g_bad_cfg
        $error("bnn_sign_packer: BW_BUS must equal bnn_pkg::BNN_BW_BUS and be >= 2");
    end

    logic [NB_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [BW_BUS-1:0] pack_q, pack_d, pack_upd;
    pack_word_t        word_q, word_d;
    logic              o_valid_q, o_valid_d;
    logic              act_bit;
    logic              accept;
    logic              close;

    bnn_sign_threshold #(
        .N_TERMS (N_TERMS)
    ) u_thr (
        .i_data   (i_data),
`ifdef BNN_SIGN_PACKER_THRESH_EN
        .i_thresh (i_thresh),
`endif
        .o_bit    (act_bit)
    );

    assign i_ready = !o_valid_q || o_ready;
    assign accept  = i_valid && i_ready;
    assign close   = accept && (i_last || (fill_cnt_q == NB_W'(BW_BUS - 1)));

    always_comb begin
        pack_upd   = pack_q;
        fill_cnt_d = fill_cnt_q;
        pack_d     = pack_q;
        o_valid_d  = o_valid_q;
        word_d     = word_q;

        for (int j = 0; j < BW_BUS; j++) begin
            if (fill_cnt_q == NB_W'(j)) begin
                pack_upd[j] = act_bit;
            end
        end

        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end

        if (accept) begin
            if (close) begin
                // A close overrides the drain above: the register reloads in the handshake cycle.
                o_valid_d    = 1'b1;
                word_d.nbits = fill_cnt_q + NB_W'(1);
                word_d.last  = i_last;
                for (int j = 0; j < BW_BUS; j++) begin
                    word_d.data[j] = (NB_W'(j) <= fill_cnt_q) ? pack_upd[j] : PAD_BIT;
                end
                fill_cnt_d = '0;
                pack_d     = '0;
            end else begin
                fill_cnt_d = fill_cnt_q + NB_W'(1);
                pack_d     = pack_upd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q <= '0;
            pack_q     <= '0;
            word_q     <= '0;
            o_valid_q  <= 1'b0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            pack_q     <= pack_d;
            word_q     <= word_d;
            o_valid_q  <= o_valid_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = word_q.data;
    assign o_nbits = word_q.nbits;
    assign o_last  = word_q.last;

endmodule

// File: tb/tb_bnn_sign_packer.sv
// Directed bench: N_TERMS=9 main instance plus an N_TERMS=8 instance sharing the stimulus for the tie rule.
module tb_bnn_sign_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic [3:0] i_data;
    logic       i_last;
    logic       o_ready;
`ifdef BNN_SIGN_PACKER_THRESH_EN
    logic [3:0] thr9;
    logic [3:0] thr8;
`endif

    logic       i_ready, o_valid, o_last;
    logic [7:0] o_data;
    logic [3:0] o_nbits;
    logic       t_i_ready, t_o_valid, t_o_last;
    logic [7:0] t_o_data;
    logic [3:0] t_o_nbits;

    int checks = 0;
    int errors = 0;
    int mon_words = 0;
    int mon_bits = 0;

    always #5 clk = ~clk;

    bnn_sign_packer #(.BW_BUS(8), .N_TERMS(9), .PAD_BIT(1'b0)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .i_last   (i_last),
`ifdef BNN_SIGN_PACKER_THRESH_EN
        .i_thresh (thr9),
`endif
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_nbits  (o_nbits),
        .o_last   (o_last)
    );

    bnn_sign_packer #(.BW_BUS(8), .N_TERMS(8), .PAD_BIT(1'b0)) u_tie (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_ready  (t_i_ready),
        .i_data   (i_data),
        .i_last   (i_last),
`ifdef BNN_SIGN_PACKER_THRESH_EN
        .i_thresh (thr8),
`endif
        .o_valid  (t_o_valid),
        .o_ready  (o_ready),
        .o_data   (t_o_data),
        .o_nbits  (t_o_nbits),
        .o_last   (t_o_last)
    );

    // A handshake seen at the falling edge completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && o_valid && o_ready) begin
            mon_words++;
            mon_bits += int'(o_nbits);
        end
    end

    task automatic send(input logic [3:0] d, input logic l);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        while (i_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: i_ready=%b required 1", i_ready);
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_data, o_nbits, o_last} !== 14'h0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", {o_valid, o_data, o_nbits, o_last});
        end
        checks++;
        if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %b required 1", i_ready); end
        checks++;
        if (t_i_ready !== 1'b1) begin errors++; $display("FAIL reset_tie_i_ready: got %b required 1", t_i_ready); end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_pack();
        logic [3:0] v [8];
        v = '{4'd0, 4'd4, 4'd5, 4'd9, 4'd5, 4'd4, 4'd8, 4'd1};
        for (int i = 0; i < 8; i++) begin
            send(v[i], 1'b0);
            if (i == 6) begin
                checks++;
                if (o_valid !== 1'b0) begin errors++; $display("FAIL pack_early_valid: got %b required 0", o_valid); end
            end
        end
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL pack_valid: got %b required 1", o_valid); end
        checks++;
        if (o_data !== 8'h5c) begin errors++; $display("FAIL pack_data: got %h required 5c", o_data); end
        checks++;
        if (o_nbits !== 4'd8) begin errors++; $display("FAIL pack_nbits: got %0d required 8", o_nbits); end
        checks++;
        if (o_last !== 1'b0) begin errors++; $display("FAIL pack_last: got %b required 0", o_last); end
        checks++;
        if (t_o_data !== 8'h7e) begin errors++; $display("FAIL pack_tie_data: got %h required 7e", t_o_data); end
        idle();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL pack_drain: got %b required 0", o_valid); end
    endtask

    task automatic test_tie();
        send(4'd4, 1'b0);
        send(4'd3, 1'b1);
        checks++;
        if (t_o_data !== 8'h01) begin errors++; $display("FAIL tie_data: got %h required 01", t_o_data); end
        checks++;
        if (t_o_nbits !== 4'd2) begin errors++; $display("FAIL tie_nbits: got %0d required 2", t_o_nbits); end
        checks++;
        if (t_o_last !== 1'b1) begin errors++; $display("FAIL tie_last: got %b required 1", t_o_last); end
        idle();
    endtask

    task automatic test_flush();
        send(4'd9, 1'b0);
        send(4'd0, 1'b0);
        send(4'd9, 1'b1);
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b required 1", o_valid); end
        checks++;
        if (o_data !== 8'h05) begin errors++; $display("FAIL flush_data: got %h required 05", o_data); end
        checks++;
        if (o_nbits !== 4'd3) begin errors++; $display("FAIL flush_nbits: got %0d required 3", o_nbits); end
        checks++;
        if (o_last !== 1'b1) begin errors++; $display("FAIL flush_last: got %b required 1", o_last); end
        idle();
    endtask

    task automatic test_simultaneous();
        send(4'd9, 1'b1);
        checks++;
        if ({o_valid, o_data} !== 9'h101) begin errors++; $display("FAIL simul_first: got %h required 101", {o_valid, o_data}); end
        send(4'd0, 1'b1);
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL simul_valid_held: got %b required 1", o_valid); end
        checks++;
        if (o_data !== 8'h00) begin errors++; $display("FAIL simul_second_data: got %h required 00", o_data); end
        checks++;
        if ({o_nbits, o_last} !== 5'b0001_1) begin errors++; $display("FAIL simul_second_meta: got %b required 00011", {o_nbits, o_last}); end
        idle();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL simul_drain: got %b required 0", o_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a [8];
        logic [3:0] b [8];
        int words0, bits0;
        a = '{4'd9, 4'd9, 4'd0, 4'd0, 4'd9, 4'd0, 4'd9, 4'd0};
        b = '{4'd0, 4'd0, 4'd9, 4'd9, 4'd0, 4'd9, 4'd0, 4'd9};
        words0 = mon_words;
        bits0  = mon_bits;
        o_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(a[i], 1'b0);
        checks++;
        if (i_ready !== 1'b0) begin errors++; $display("FAIL bp_i_ready_low: got %b required 0", i_ready); end
        i_valid = 1'b1;
        i_data  = b[0];
        i_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({o_valid, o_data} !== 9'h153) begin
                errors++; $display("FAIL bp_hold_%0d: got %h required 153", c, {o_valid, o_data});
            end
            checks++;
            if (i_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready_%0d: got %b required 0", c, i_ready); end
        end
        o_ready = 1'b1;
        #1;
        checks++;
        if (i_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", i_ready); end
        @(posedge clk); #1;
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_after_release: got %b required 0", o_valid); end
        for (int i = 1; i < 8; i++) send(b[i], (i == 7) ? 1'b1 : 1'b0);
        checks++;
        if ({o_valid, o_data} !== 9'h1ac) begin errors++; $display("FAIL bp_second_word: got %h required 1ac", {o_valid, o_data}); end
        checks++;
        if ({o_nbits, o_last} !== 5'b1000_1) begin errors++; $display("FAIL bp_second_meta: got %b required 10001", {o_nbits, o_last}); end
        idle();
        checks++;
        if (mon_bits - bits0 !== 16) begin errors++; $display("FAIL bp_bit_count: got %0d required 16", mon_bits - bits0); end
        checks++;
        if (mon_words - words0 !== 2) begin errors++; $display("FAIL bp_word_count: got %0d required 2", mon_words - words0); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] v [8];
        v = '{4'd0, 4'd9, 4'd0, 4'd9, 4'd0, 4'd9, 4'd0, 4'd9};
        for (int i = 0; i < 5; i++) send(4'd9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_data, o_nbits, o_last} !== 14'h0) begin
            errors++; $display("FAIL rstmid_outputs: got %h required 0", {o_valid, o_data, o_nbits, o_last});
        end
        checks++;
        if (i_ready !== 1'b1) begin errors++; $display("FAIL rstmid_i_ready: got %b required 1", i_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(v[i], 1'b0);
            if (i == 2) begin
                checks++;
                if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_fill: got %b required 0", o_valid); end
            end
        end
        checks++;
        if ({o_valid, o_data} !== 9'h1aa) begin errors++; $display("FAIL rstmid_word: got %h required 1aa", {o_valid, o_data}); end
        checks++;
        if ({o_nbits, o_last} !== 5'b1000_0) begin errors++; $display("FAIL rstmid_meta: got %b required 10000", {o_nbits, o_last}); end
        idle();
    endtask

`ifdef BNN_SIGN_PACKER_THRESH_EN
    task automatic test_thresh();
        thr9 = 4'd7;
        send(4'd6, 1'b0);
        send(4'd7, 1'b1);
        checks++;
        if ({o_valid, o_data} !== 9'h102) begin errors++; $display("FAIL thresh_data: got %h required 102", {o_valid, o_data}); end
        checks++;
        if ({o_nbits, o_last} !== 5'b0010_1) begin errors++; $display("FAIL thresh_meta: got %b required 00101", {o_nbits, o_last}); end
        thr9 = 4'd5;
        idle();
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = 4'd0;
        i_last  = 1'b0;
        o_ready = 1'b1;
`ifdef BNN_SIGN_PACKER_THRESH_EN
        thr9 = 4'd5;
        thr8 = 4'd4;
`endif
        test_reset();
        test_pack();
        test_tie();
        test_flush();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
`ifdef BNN_SIGN_PACKER_THRESH_EN
        test_thresh();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
